// File: rtl/instr_register_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_register_resp_if
// Purpose  : Write/read bus of the instruction register file. The master
//            issues writes and read requests; the slave returns responses.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_register_resp_if #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32
);
    logic                  load_en;
    logic [ADDR_W-1:0]     write_pointer;
    logic [3:0]            opcode;
    logic [OP_W-1:0]       operand_a;
    logic [OP_W-1:0]       operand_b;
    logic                  rd_req;
    logic [ADDR_W-1:0]     read_pointer;
    logic                  rd_valid;
    logic [4+2*OP_W-1:0]   instruction_word;
    logic [2*OP_W-1:0]     result;
    logic                  rd_err;
    logic [ADDR_W:0]       num_written;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b,
        output rd_req, read_pointer,
        input  rd_valid, instruction_word, result, rd_err, num_written
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b,
        input  rd_req, read_pointer,
        output rd_valid, instruction_word, result, rd_err, num_written
    );
endinterface
`default_nettype wire

// File: rtl/instr_register_resp.sv
`default_nettype none
// ============================================================================
// Module   : instr_register_resp
// Purpose  : 2**ADDR_W-entry instruction register file with a two-stage read
//            pipeline that returns the stored word and its computed result.
// Revision : 1.0 - initial release
// ============================================================================
module instr_register_resp #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instr_register_resp_if.slave bus
);
    localparam int c_ENTRIES = 2**ADDR_W;
    localparam int c_IW_W    = 4 + 2*OP_W;

    localparam logic [3:0] c_OP_ZERO  = 4'd0;
    localparam logic [3:0] c_OP_PASSA = 4'd1;
    localparam logic [3:0] c_OP_PASSB = 4'd2;
    localparam logic [3:0] c_OP_ADD   = 4'd3;
    localparam logic [3:0] c_OP_SUB   = 4'd4;
    localparam logic [3:0] c_OP_MULT  = 4'd5;
    localparam logic [3:0] c_OP_DIV   = 4'd6;
    localparam logic [3:0] c_OP_MOD   = 4'd7;

    logic [c_IW_W-1:0]  r_mem [c_ENTRIES];
    logic [c_ENTRIES-1:0] r_valid;
    logic [ADDR_W:0]    r_count;

    logic               r_s1_valid;
    logic               r_s1_hit;
    logic [c_IW_W-1:0]  r_s1_word;

    logic               r_rd_valid;
    logic [c_IW_W-1:0]  r_iw;
    logic [2*OP_W-1:0]  r_result;
    logic               r_err;

    logic [3:0]                w_opc;
    logic [OP_W-1:0]           w_a;
    logic [OP_W-1:0]           w_b;
    logic signed [2*OP_W-1:0]  w_ax;
    logic signed [2*OP_W-1:0]  w_bx;
    logic signed [2*OP_W-1:0]  w_res;
    logic                      w_err;

    // Storage array: no reset, valid bits alone decide what a read returns.
    always_ff @(posedge clk) begin
        if (!reset && bus.load_en) begin
            r_mem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b};
        end
    end

    // Valid bits and distinct-entry count; a rewrite does not bump the count,
    // so it saturates naturally at the entry count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (bus.load_en) begin
            r_valid[bus.write_pointer] <= 1'b1;
            if (!r_valid[bus.write_pointer]) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Stage 1: capture the addressed entry; old contents win on a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_word  <= '0;
        end else begin
            r_s1_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_s1_hit  <= r_valid[bus.read_pointer];
                r_s1_word <= r_valid[bus.read_pointer] ? r_mem[bus.read_pointer] : '0;
            end
        end
    end

    assign w_opc = r_s1_word[c_IW_W-1 -: 4];
    assign w_a   = r_s1_word[2*OP_W-1 -: OP_W];
    assign w_b   = r_s1_word[OP_W-1:0];
    assign w_ax  = {{OP_W{w_a[OP_W-1]}}, w_a};
    assign w_bx  = {{OP_W{w_b[OP_W-1]}}, w_b};

    // Stage 2 arithmetic at double width so MULT keeps the full product and
    // DIV of the most negative value by -1 does not overflow.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        if (!r_s1_hit) begin
            w_err = 1'b1;
        end else begin
            case (w_opc)
                c_OP_ZERO:  w_res = '0;
                c_OP_PASSA: w_res = w_ax;
                c_OP_PASSB: w_res = w_bx;
                c_OP_ADD:   w_res = w_ax + w_bx;
                c_OP_SUB:   w_res = w_ax - w_bx;
                c_OP_MULT:  w_res = w_ax * w_bx;
                c_OP_DIV: begin
                    if (w_b == '0) w_err = 1'b1;
                    else           w_res = w_ax / w_bx;
                end
                c_OP_MOD: begin
                    if (w_b == '0) w_err = 1'b1;
                    else           w_res = w_ax % w_bx;
                end
                default:    w_err = 1'b1;
            endcase
        end
    end

    // Stage 2 registers: response fields hold their value between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_iw       <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_iw     <= r_s1_word;
                r_result <= w_res;
                r_err    <= w_err;
            end
        end
    end

    assign bus.rd_valid         = r_rd_valid;
    assign bus.instruction_word = r_iw;
    assign bus.result           = r_result;
    assign bus.rd_err           = r_err;
    assign bus.num_written      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_register_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_register_resp
// Purpose  : Directed scoreboard bench for instr_register_resp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_register_resp;
    typedef struct packed {
        logic [67:0] iw;
        logic [63:0] res;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] cyc;
    int          n_vec;
    int          n_bad;
    exp_t        q[$];

    instr_register_resp_if #(.ADDR_W(5), .OP_W(32)) bus ();

    instr_register_resp #(.ADDR_W(5), .OP_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to check response latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rd_valid: got 1, expected 0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("latency_cycle", cyc, e.cyc);
                chk("instruction_word", bus.instruction_word, e.iw);
                chk("result", bus.result, e.res);
                chk("rd_err", bus.rd_err, e.err);
            end
        end
    end

    // One cycle of stimulus; a read request enqueues its expected response.
    task automatic step(input logic le, input logic [4:0] wp, input logic [3:0] opc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input logic [4:0] rp,
                        input logic [67:0] eiw, input logic [63:0] eres, input logic eerr);
        exp_t e;
        bus.load_en       = le;
        bus.write_pointer = wp;
        bus.opcode        = opc;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.rd_req        = rq;
        bus.read_pointer  = rp;
        if (rq) begin
            e.iw  = eiw;
            e.res = eres;
            e.err = eerr;
            e.cyc = cyc + 2;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] wp, input logic [3:0] opc,
                      input logic [31:0] a, input logic [31:0] b);
        step(1'b1, wp, opc, a, b, 1'b0, 5'd0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] rp, input logic [67:0] eiw,
                      input logic [63:0] eres, input logic eerr);
        step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, rp, eiw, eres, eerr);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b0, 5'd0, '0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.load_en = 1'b0; bus.write_pointer = '0; bus.opcode = '0;
        bus.operand_a = '0; bus.operand_b = '0;
        bus.rd_req = 1'b0; bus.read_pointer = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_iw", bus.instruction_word, 68'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_rd_err", bus.rd_err, 1'b0);
        chk("reset_num_written", bus.num_written, 6'd0);

        // Read of an unwritten entry
        rd(5'd0, 68'd0, 64'd0, 1'b1);

        // ADD -7 + 12
        wr(5'd3, 4'd3, 32'hFFFF_FFF9, 32'd12);
        rd(5'd3, {4'd3, 32'hFFFF_FFF9, 32'd12}, 64'd5, 1'b0);
        chk("num_written_after_first", bus.num_written, 6'd1);

        // MULT full product, back-to-back reads
        wr(5'd5, 4'd5, 32'h7FFF_FFFF, 32'd2);
        rd(5'd5, {4'd5, 32'h7FFF_FFFF, 32'd2}, 64'h0000_0000_FFFF_FFFE, 1'b0);
        rd(5'd3, {4'd3, 32'hFFFF_FFF9, 32'd12}, 64'd5, 1'b0);

        // DIV by zero, MOD with negative dividend
        wr(5'd1, 4'd6, 32'd9, 32'd0);
        wr(5'd2, 4'd7, 32'hFFFF_FFF9, 32'd2);
        rd(5'd1, {4'd6, 32'd9, 32'd0}, 64'd0, 1'b1);
        rd(5'd2, {4'd7, 32'hFFFF_FFF9, 32'd2}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Read-before-write on same address, then rewrite leaves count alone
        wr(5'd4, 4'd1, 32'd1, 32'd0);
        idle();
        chk("num_written_after_addr4", bus.num_written, 6'd5);
        step(1'b1, 5'd4, 4'd2, 32'd0, 32'd9, 1'b1, 5'd4, {4'd1, 32'd1, 32'd0}, 64'd1, 1'b0);
        rd(5'd4, {4'd2, 32'd0, 32'd9}, 64'd9, 1'b0);
        chk("num_written_after_rewrite", bus.num_written, 6'd5);

        // More opcodes and corner values
        wr(5'd6, 4'd4, 32'd5, 32'd12);
        wr(5'd7, 4'd6, 32'hFFFF_FFF9, 32'd2);
        wr(5'd13, 4'd7, 32'd7, 32'hFFFF_FFFE);
        wr(5'd8, 4'd9, 32'd1, 32'd1);
        wr(5'd9, 4'd0, 32'd5, 32'd5);
        wr(5'd10, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        wr(5'd11, 4'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
        rd(5'd6, {4'd4, 32'd5, 32'd12}, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        rd(5'd7, {4'd6, 32'hFFFF_FFF9, 32'd2}, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        rd(5'd13, {4'd7, 32'd7, 32'hFFFF_FFFE}, 64'd1, 1'b0);
        rd(5'd8, {4'd9, 32'd1, 32'd1}, 64'd0, 1'b1);
        rd(5'd9, {4'd0, 32'd5, 32'd5}, 64'd0, 1'b0);
        rd(5'd10, {4'd6, 32'h8000_0000, 32'hFFFF_FFFF}, 64'h0000_0000_8000_0000, 1'b0);
        rd(5'd11, {4'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF}, 64'hFFFF_FFFE_8000_0003, 1'b0);

        // Simultaneous write and read at different addresses
        step(1'b1, 5'd12, 4'd2, 32'd0, 32'd44, 1'b1, 5'd3, {4'd3, 32'hFFFF_FFF9, 32'd12}, 64'd5, 1'b0);
        rd(5'd12, {4'd2, 32'd0, 32'd44}, 64'd44, 1'b0);
        chk("num_written_mid", bus.num_written, 6'd13);

        // Fill every entry, rewrite addr 0: count saturates at 32
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 4'd1, 32'(i), 32'd0);
        end
        wr(5'd0, 4'd2, 32'd0, 32'd77);
        idle();
        chk("num_written_full", bus.num_written, 6'd32);
        rd(5'd0, {4'd2, 32'd0, 32'd77}, 64'd77, 1'b0);
        repeat (3) idle();

        // Read in flight when reset asserts must not produce a response
        bus.rd_req = 1'b1;
        bus.read_pointer = 5'd1;
        @(negedge clk);
        reset = 1'b1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("flush_rd_valid_0", bus.rd_valid, 1'b0);
        chk("flush_num_written", bus.num_written, 6'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("flush_rd_valid_1", bus.rd_valid, 1'b0);
        rd(5'd0, 68'd0, 64'd0, 1'b1);
        repeat (3) idle();

        // Every expected response must have arrived
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("pending_responses", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_register_resp.md
INSTR_REGISTER_RESP -- requirements
Module: instr_register_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: address width; entry count is 2**ADDR_W (32).
REQ-002 SHALL have parameter OP_W, default 32: signed operand width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port load_en  in  1  write strobe.
REQ-006 SHALL have port write_pointer  in  ADDR_W  write address.
REQ-007 SHALL have port opcode  in  4  opcode: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-008 SHALL have port operand_a  in  OP_W  signed operand A.
REQ-009 SHALL have port operand_b  in  OP_W  signed operand B.
REQ-010 SHALL have port rd_req  in  1  read request.
REQ-011 SHALL have port read_pointer  in  ADDR_W  read address, sampled with rd_req.
REQ-012 SHALL have port rd_valid  out  1  read response valid.
REQ-013 SHALL have port instruction_word  out  4+2*OP_W  stored {opc, op_a, op_b}, opc in MSBs.
REQ-014 SHALL have port result  out  2*OP_W  signed computed result of stored entry.
REQ-015 SHALL have port rd_err  out  1  response error flag.
REQ-016 SHALL have port num_written  out  ADDR_W+1  count of distinct entries written since reset.

Function
REQ-017 SHALL write {opcode, operand_a, operand_b} to entry write_pointer on any edge with load_en=1, and set that entry's valid bit.
REQ-018 SHALL increment num_written only when a write targets an entry whose valid bit was clear; rewriting an entry leaves the count unchanged; maximum value 32, no wrap.
REQ-019 SHALL run a 2-stage read pipeline: rd_req sampled at edge N -> rd_valid=1 with response for edge N+2 sampling; one request accepted per cycle, no stall, no backpressure.
REQ-020 SHALL hold rd_valid=0 in any cycle without a corresponding request two edges earlier; instruction_word/result/rd_err hold last values when rd_valid=0.
REQ-021 SHALL compute result in stage 2, sign-extended to 2*OP_W: ZERO->0, PASSA->op_a, PASSB->op_b, ADD->op_a+op_b, SUB->op_a-op_b, MULT->op_a*op_b (full product), DIV->op_a/op_b truncated toward zero, MOD->op_a%op_b (sign follows op_a).
REQ-022 SHALL, for DIV or MOD with op_b=0, return result=0 and rd_err=1.
REQ-023 SHALL, for stored opcode 8..15, return result=0 and rd_err=1.
REQ-024 SHALL, for a read of an entry with valid bit clear, return instruction_word=0, result=0, rd_err=1.
REQ-025 SHALL, when load_en and rd_req target the same address on the same edge, return the pre-write contents (read-before-write).
REQ-026 SHALL accept simultaneous write and read to different addresses with no interaction.

Reset
REQ-027 SHALL, on an edge with reset=1, clear all valid bits, num_written=0, rd_valid=0, instruction_word=0, result=0, rd_err=0, and flush both pipeline stages.
REQ-028 SHALL ignore load_en and rd_req on reset edges; requests in flight when reset asserts SHALL produce no rd_valid.
REQ-029 SHALL leave storage array contents unspecified after reset; valid bits alone govern read behaviour.

Verification
REQ-030 Reset, then read addr 0 -> rd_valid at +2 edges, rd_err=1, instruction_word=0, result=0.
REQ-031 Write addr 3 {ADD, -7, 12}, read addr 3 next cycle -> rd_valid 2 edges later, instruction_word opc=3, op_a=-7, op_b=12, result=5, rd_err=0, num_written=1.
REQ-032 Write addr 5 {MULT, 0x7FFFFFFF, 2}, back-to-back reads addrs 5,3 -> consecutive rd_valid cycles, result=0xFFFFFFFE then 5.
REQ-033 Write {DIV, 9, 0} addr 1 and {MOD, -7, 2} addr 2 -> reads give result=0, rd_err=1; then result=-1, rd_err=0.
REQ-034 Write addr 4 {PASSA,1,0}, then same-edge write addr 4 {PASSB,0,9} with read addr 4 -> result=1; subsequent read -> result=9; num_written unchanged at 1 for addr 4.
REQ-035 Write all 32 entries then rewrite addr 0 -> num_written=32; issue read, assert reset next edge -> no rd_valid, num_written=0.
